// File: rtl/sigmoid_coef_seq.sv
`default_nettype none
// ============================================================================
// Module   : sigmoid_coef_seq
// Brief    : Classifies |x| into one of four PLAN sigmoid segments and emits
//            (x, gradient, offset) over a valid/ready handshake.
//            Optional macro SIGMOID_COEF_PARALLEL_EN: single-cycle search.
// Revision : 1.0 - initial release
// ============================================================================
module sigmoid_coef_seq #(
    parameter int BITS = 16,
    parameter int FRAC = 10
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [BITS-1:0] in_x,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [BITS-1:0] out_x,
    output logic [BITS-1:0] out_gradient,
    output logic [BITS-1:0] out_offset,
    output logic [1:0]      out_seg
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SEARCH = 2'd1;
    localparam logic [1:0] S_EMIT   = 2'd2;

    // Constants built from exact binary fractions so they track FRAC (>= 5).
    localparam logic [BITS-1:0] C_BP0   = BITS'(1 << FRAC);
    localparam logic [BITS-1:0] C_BP1   = BITS'(19 << (FRAC - 3));
    localparam logic [BITS-1:0] C_BP2   = BITS'(5 << FRAC);
    localparam logic [BITS-1:0] C_GRAD0 = BITS'(1 << (FRAC - 2));
    localparam logic [BITS-1:0] C_GRAD1 = BITS'(1 << (FRAC - 3));
    localparam logic [BITS-1:0] C_GRAD2 = BITS'(1 << (FRAC - 5));
    localparam logic [BITS-1:0] C_OFF0  = BITS'(1 << (FRAC - 1));
    localparam logic [BITS-1:0] C_OFF1  = BITS'(5 << (FRAC - 3));
    localparam logic [BITS-1:0] C_OFF2  = BITS'(27 << (FRAC - 5));
    localparam logic [BITS-1:0] C_OFF3  = BITS'(1 << FRAC);
    localparam logic [BITS-1:0] C_MIN   = {1'b1, {(BITS-1){1'b0}}};
    localparam logic [BITS-1:0] C_MAX   = {1'b0, {(BITS-1){1'b1}}};

    logic [1:0]      r_state;
    logic [BITS-1:0] r_x;
    logic [BITS-1:0] r_abs;
    logic [1:0]      r_seg;
    logic [BITS-1:0] w_abs;
    logic            w_found;
    logic [1:0]      w_seg;
    logic [BITS-1:0] w_grad;
    logic [BITS-1:0] w_off;

    assign in_ready = (r_state == S_IDLE);

    // The most-negative input has no positive counterpart; clamp it.
    always_comb begin
        if (in_x == C_MIN)
            w_abs = C_MAX;
        else if (in_x[BITS-1])
            w_abs = -in_x;
        else
            w_abs = in_x;
    end

`ifdef SIGMOID_COEF_PARALLEL_EN
    always_comb begin
        w_found = 1'b1;
        if (r_abs < C_BP0)
            w_seg = 2'd0;
        else if (r_abs < C_BP1)
            w_seg = 2'd1;
        else if (r_abs < C_BP2)
            w_seg = 2'd2;
        else
            w_seg = 2'd3;
    end
`else
    logic [1:0]      r_idx;
    logic [BITS-1:0] w_bp_sel;

    always_comb begin
        case (r_idx)
            2'd0:    w_bp_sel = C_BP0;
            2'd1:    w_bp_sel = C_BP1;
            default: w_bp_sel = C_BP2;
        endcase
        w_found = (r_abs < w_bp_sel) || (r_idx == 2'd2);
        w_seg   = (r_abs < w_bp_sel) ? r_idx : 2'd3;
    end
`endif

    always_comb begin
        case (r_seg)
            2'd0:    begin w_grad = C_GRAD0;  w_off = C_OFF0; end
            2'd1:    begin w_grad = C_GRAD1;  w_off = C_OFF1; end
            2'd2:    begin w_grad = C_GRAD2;  w_off = C_OFF2; end
            default: begin w_grad = '0;       w_off = C_OFF3; end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_x          <= '0;
            r_abs        <= '0;
            r_seg        <= '0;
`ifndef SIGMOID_COEF_PARALLEL_EN
            r_idx        <= '0;
`endif
            out_valid    <= 1'b0;
            out_x        <= '0;
            out_gradient <= '0;
            out_offset   <= '0;
            out_seg      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_x     <= in_x;
                        r_abs   <= w_abs;
`ifndef SIGMOID_COEF_PARALLEL_EN
                        r_idx   <= 2'd0;
`endif
                        r_state <= S_SEARCH;
                    end
                end
                S_SEARCH: begin
                    if (w_found) begin
                        r_seg   <= w_seg;
                        r_state <= S_EMIT;
                    end
`ifndef SIGMOID_COEF_PARALLEL_EN
                    else begin
                        r_idx <= r_idx + 2'd1;
                    end
`endif
                end
                S_EMIT: begin
                    // First EMIT cycle loads the triple; it is then held until taken.
                    if (!out_valid) begin
                        out_x        <= r_x;
                        out_gradient <= w_grad;
                        out_offset   <= w_off;
                        out_seg      <= r_seg;
                        out_valid    <= 1'b1;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        r_state   <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sigmoid_coef_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_sigmoid_coef_seq
// Brief    : Directed self-checking bench for sigmoid_coef_seq; honours
//            SIGMOID_COEF_PARALLEL_EN for the expected latency.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sigmoid_coef_seq;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_x;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_x;
    logic [15:0] out_gradient;
    logic [15:0] out_offset;
    logic [1:0]  out_seg;

    int n_assert = 0;
    int n_fail   = 0;

    sigmoid_coef_seq #(.BITS(16), .FRAC(10)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_x         (in_x),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_x        (out_x),
        .out_gradient (out_gradient),
        .out_offset   (out_offset),
        .out_seg      (out_seg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int exp_lat(input int seg);
`ifdef SIGMOID_COEF_PARALLEL_EN
        return 2;
`else
        return 2 + ((seg > 2) ? 2 : seg);
`endif
    endfunction

    // Accepts one sample, measures latency to out_valid, checks the triple and
    // the post-handshake return to IDLE (out_ready held high).
    task automatic send(input string tag, input logic [15:0] x, input int seg,
                        input logic [15:0] grad, input logic [15:0] off);
        int lat;
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_x     = x;
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 10) begin
            tick();
            lat++;
        end
        chk({tag, "_latency"},  32'(lat),          32'(exp_lat(seg)));
        chk({tag, "_out_x"},    32'(out_x),        32'(x));
        chk({tag, "_seg"},      32'(out_seg),      32'(seg));
        chk({tag, "_gradient"}, 32'(out_gradient), 32'(grad));
        chk({tag, "_offset"},   32'(out_offset),   32'(off));
        tick();
        chk({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
        chk({tag, "_ready_back"}, 32'(in_ready),  32'd1);
    endtask

    initial begin
        int  lat;
        logic seen;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_x      = 16'h0000;
        out_ready = 1'b1;

        // Reset held three cycles
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_out_valid", 32'(out_valid), 32'd0);
        end
        chk("rst_out_x",    32'(out_x),        32'd0);
        chk("rst_gradient", 32'(out_gradient), 32'd0);
        chk("rst_offset",   32'(out_offset),   32'd0);
        chk("rst_seg",      32'(out_seg),      32'd0);
        rst = 1'b0;
        tick();
        chk("idle_in_ready",  32'(in_ready),  32'd1);
        chk("idle_out_valid", 32'(out_valid), 32'd0);

        // Segment sweep and sign cases
        send("s0_0p5",   16'h0200, 0, 16'd256, 16'd512);
        send("s1_1p0",   16'h0400, 1, 16'd128, 16'd640);
        send("s2_2p375", 16'h0980, 2, 16'd32,  16'd864);
        send("s3_5p0",   16'h1400, 3, 16'd0,   16'd1024);
        send("neg_1p5",  16'hFA00, 1, 16'd128, 16'd640);
        send("most_neg", 16'h8000, 3, 16'd0,   16'd1024);
        send("s0_max",   16'h03FF, 0, 16'd256, 16'd512);
        send("s2_neg5m", 16'hEC01, 2, 16'd32,  16'd864);

        // Backpressure: out_ready low for 5 valid cycles, stray in_valid ignored
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_x      = 16'h0200;
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 10) begin
            tick();
            lat++;
        end
        chk("bp_latency", 32'(lat), 32'(exp_lat(0)));
        for (int i = 0; i < 6; i++) begin
            if (i == 5) out_ready = 1'b1;
            in_valid = (i >= 1 && i <= 3);
            in_x     = 16'h1400;
            chk("bp_valid",    32'(out_valid),    32'd1);
            chk("bp_out_x",    32'(out_x),        32'h0200);
            chk("bp_gradient", 32'(out_gradient), 32'd256);
            chk("bp_offset",   32'(out_offset),   32'd512);
            chk("bp_seg",      32'(out_seg),      32'd0);
            chk("bp_in_ready", 32'(in_ready),     32'd0);
            tick();
        end
        in_valid = 1'b0;
        chk("bp_valid_drop", 32'(out_valid), 32'd0);
        chk("bp_ready_back", 32'(in_ready),  32'd1);
        tick();
        chk("bp_no_stray_accept", 32'(in_ready), 32'd1);

        // Reset mid-search discards the in-flight sample
        in_valid = 1'b1;
        in_x     = 16'h1400;
        tick();
        in_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst  = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (out_valid) seen = 1'b1;
            tick();
        end
        chk("midrst_no_valid", 32'(seen),     32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        send("after_rst", 16'h0200, 0, 16'd256, 16'd512);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sigmoid_coef_seq.md
# sigmoid_coef_seq

Stream-side coefficient sequencer for the piecewise-linear (PLAN) sigmoid datapath in the VAE decoder. It accepts one fixed-point sample per valid/ready handshake and classifies |x| into one of four PLAN segments with a small search state machine. It then emits the triple (x, gradient, offset) that the combinational sigmoid multiply-add stage consumes. It replaces hard-wired gradient/offset inputs so that a single sigmoid datapath can serve a stream of activations.

## Interface
- BITS, 16, word width of x, gradient and offset (signed two's complement).
- FRAC, 10, fractional bits. All constants are derived as round(value·2^FRAC).
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  in_x is valid.
- in_ready  output  1  block can accept a sample. High only in IDLE.
- in_x  input  BITS  input activation, signed Q(BITS-FRAC).FRAC.
- out_valid  output  1  output triple is valid.
- out_ready  input  1  downstream accepts the triple.
- out_x  output  BITS  registered copy of accepted in_x, sign preserved.
- out_gradient  output  BITS  segment gradient, non-negative.
- out_offset  output  BITS  segment offset magnitude, non-negative. Sign selection stays in the sigmoid datapath.
- out_seg  output  2  segment index 0..3, for debug and verification.

## Operation
- Constants at FRAC=10:
  - Breakpoints: bp0=1024 (1.0), bp1=2432 (2.375), bp2=5120 (5.0).
  - Gradients, seg0..3: 256, 128, 32, 0.
  - Offsets, seg0..3: 512, 640, 864, 1024.
- Segment rule on a = |x|:
  - seg0: a < bp0.
  - seg1: bp0 ≤ a < bp1.
  - seg2: bp1 ≤ a < bp2.
  - seg3: a ≥ bp2.
  - A value equal to a breakpoint belongs to the upper segment.
- Absolute value: a = x<0 ? -x : x. The most-negative input (0x8000) saturates to 0x7FFF, giving seg3.
- FSM states: IDLE, SEARCH, EMIT. Transitions:
  - IDLE → SEARCH on in_valid && in_ready. Latch x and a; search index idx=0.
  - SEARCH: compare a with bp[idx].
    - If a < bp[idx]: seg=idx, go to EMIT.
    - Else if idx==2: seg=3, go to EMIT.
    - Else idx++.
  - On entry to EMIT, out_x, out_gradient, out_offset and out_seg are registered and out_valid=1.
  - EMIT → IDLE on out_valid && out_ready. out_valid drops on the next edge.
- Outputs are held stable while out_valid && !out_ready. Backpressure has no depth limit.
- in_ready = (state==IDLE), combinational from state only, not from out_ready.
- Only one sample is in flight at a time. No back-to-back acceptance.

## Timing
- Reset (rst=1 at an edge):
  - state=IDLE, out_valid=0.
  - out_x, out_gradient, out_offset, out_seg all 0.
  - in_ready=1 from the first cycle after reset.
- Reset mid-operation (SEARCH or EMIT) discards the sample. No output handshake follows.
- Accept at edge T. Without the macro, out_valid rises at edge T+2+min(seg,2):
  - seg0: 2 cycles.
  - seg1: 3 cycles.
  - seg2: 4 cycles.
  - seg3: 4 cycles.
- Output handshake at edge E: in_ready=1 during cycle E+1. The earliest next accept is edge E+1.
- in_valid asserted outside IDLE is ignored. in_x is not sampled then.

## Configuration
- SIGMOID_COEF_PARALLEL_EN:
  - Defined: SEARCH compares a against all three breakpoints in one cycle and always exits after one SEARCH cycle. Latency is fixed at 2 cycles for every segment.
  - Undefined: sequential one-comparator search as above, with latency 2–4 cycles.
  - Segment results, reset behaviour and handshake rules are identical in both builds.

## Test plan
- Reset then idle: rst held 3 cycles, in_valid=0 → out_valid=0, all outputs 0, in_ready=1 after release.
- Segment sweep, out_ready=1, one sample per handshake:
  - x=0x0200 (0.5) → seg0, grad 256, off 512, latency 2.
  - x=0x0400 (1.0, boundary) → seg1, grad 128, off 640, latency 3.
  - x=0x0980 (2.375) → seg2, grad 32, off 864, latency 4.
  - x=0x1400 (5.0) → seg3, grad 0, off 1024, latency 4.
- Negative and saturation cases:
  - x=0xFA00 (-1.5) → seg1, out_x=0xFA00.
  - x=0x8000 → seg3, out_x=0x8000.
- Backpressure: x=0x0200, out_ready=0 for 5 cycles then 1:
  - out_valid and triple stable for all 6 cycles.
  - in_ready=0 throughout; a second in_valid during this window is not accepted.
  - in_ready=1 the cycle after the handshake.
- Reset mid-search: accept x=0x1400, assert rst at T+2 → no out_valid ever. After release, x=0x0200 gives seg0 normally.
- Macro build (SIGMOID_COEF_PARALLEL_EN): repeat the sweep → same triples, latency 2 for all four samples.
